wr_req_queue_router: RTL

- Parametrised write-request controller for the cross-bar port handler.
- Captures master write requests (req/cmd/addr/wdata) into a DEPTH-entry queue and forwards them one at a time to one of NSLAVES slave ports, selected by the top address bits.
- Waits for the slave ack on each request, and aborts with an error pulse if ack does not arrive within TIMEOUT cycles.
- Decouples the master from slave latency, which allows multiple posted writes.

---
 rtl/wr_req_queue_router.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/wr_req_queue_router.sv
// Write-request queue router: captures master writes into a FIFO and forwards them
// one at a time to a slave port chosen by the top address bits, with ack timeout.
module wr_req_queue_router #(
    parameter int unsigned AWIDTH  = 32,
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned NSLAVES = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         req_i,
    input  logic                         cmd_i,
    input  logic [AWIDTH-1:0]            addr_i,
    input  logic [DWIDTH-1:0]            wdata_i,
    output logic                         accept_o,
    output logic                         out_req_o,
    output logic [$clog2(NSLAVES)-1:0]   out_sel_o,
    output logic [AWIDTH-1:0]            out_addr_o,
    output logic [DWIDTH-1:0]            out_wdata_o,
    input  logic                         out_ack_i,
    output logic                         timeout_err_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);

    localparam int unsigned SEL_W = $clog2(NSLAVES);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned TO_W  = $clog2(TIMEOUT);
    localparam int unsigned ENT_W = SEL_W + AWIDTH + DWIDTH;

    typedef enum logic {IN_ARMED, IN_HELD} in_state_e;
    typedef enum logic {OUT_IDLE, OUT_WAIT_ACK} out_state_e;

    in_state_e         in_st_q, in_st_d;
    out_state_e        out_st_q, out_st_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  level_q, level_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              accept_q, accept_d;
    logic              out_req_q, out_req_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;
    logic [AWIDTH-1:0] out_addr_q, out_addr_d;
    logic [DWIDTH-1:0] out_wdata_q, out_wdata_d;
    logic              terr_q, terr_d;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [ENT_W-1:0]  wr_entry;
    logic [ENT_W-1:0]  rd_entry;
    logic              push;
    logic              pop;

    assign wr_entry = {addr_i[AWIDTH-1 -: SEL_W], addr_i, wdata_i};
    assign rd_entry = mem_q[rd_ptr_q];

    // Next-state logic for both the capture side and the slave side
    always_comb begin
        in_st_d     = in_st_q;
        out_st_d    = out_st_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        to_cnt_d    = to_cnt_q;
        out_req_d   = out_req_q;
        out_sel_d   = out_sel_q;
        out_addr_d  = out_addr_q;
        out_wdata_d = out_wdata_q;
        accept_d    = 1'b0;
        terr_d      = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;

        case (in_st_q)
            IN_ARMED: begin
                // a full queue defers capture; the push check uses last edge's level
                if (req_i && cmd_i && (level_q < CNT_W'(DEPTH))) begin
                    push     = 1'b1;
                    accept_d = 1'b1;
                    in_st_d  = IN_HELD;
                end
            end
            IN_HELD: begin
                if (!req_i) begin
                    in_st_d = IN_ARMED;
                end
            end
            default: in_st_d = IN_ARMED;
        endcase

        case (out_st_q)
            OUT_IDLE: begin
                if (level_q != '0) begin
                    out_sel_d   = rd_entry[ENT_W-1 -: SEL_W];
                    out_addr_d  = rd_entry[DWIDTH +: AWIDTH];
                    out_wdata_d = rd_entry[DWIDTH-1:0];
                    out_req_d   = 1'b1;
                    to_cnt_d    = '0;
                    out_st_d    = OUT_WAIT_ACK;
                end
            end
            OUT_WAIT_ACK: begin
                // ack wins over a timeout landing on the same edge
                if (out_ack_i || (to_cnt_q == TO_W'(TIMEOUT - 1))) begin
                    pop         = 1'b1;
                    terr_d      = ~out_ack_i;
                    out_req_d   = 1'b0;
                    out_sel_d   = '0;
                    out_addr_d  = '0;
                    out_wdata_d = '0;
                    out_st_d    = OUT_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: out_st_d = OUT_IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        level_d = level_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            in_st_q     <= IN_ARMED;
            out_st_q    <= OUT_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            to_cnt_q    <= '0;
            accept_q    <= 1'b0;
            out_req_q   <= 1'b0;
            out_sel_q   <= '0;
            out_addr_q  <= '0;
            out_wdata_q <= '0;
            terr_q      <= 1'b0;
        end else begin
            in_st_q     <= in_st_d;
            out_st_q    <= out_st_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            to_cnt_q    <= to_cnt_d;
            accept_q    <= accept_d;
            out_req_q   <= out_req_d;
            out_sel_q   <= out_sel_d;
            out_addr_q  <= out_addr_d;
            out_wdata_q <= out_wdata_d;
            terr_q      <= terr_d;
        end
    end

    // Queue storage needs no reset; validity is tracked by level and pointers
    always_ff @(posedge aclk) begin
        if (aresetn && push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign accept_o      = accept_q;
    assign out_req_o     = out_req_q;
    assign out_sel_o     = out_sel_q;
    assign out_addr_o    = out_addr_q;
    assign out_wdata_o   = out_wdata_q;
    assign timeout_err_o = terr_q;
    assign level_o       = level_q;

endmodule
